// File: rtl/write_pointer_full_block.sv
// write_pointer_full_block: write-side pointer, full/almost-full/level and sticky overflow for the async FIFO
module write_pointer_full_block #(
  parameter int addr_size          = 4,
  parameter int almost_full_margin = 2
) (
  input  logic                 write_clock_i,
  input  logic                 write_reset_n_i,
  input  logic                 write_enable_i,
  input  logic                 overflow_clear_i,
  input  logic [addr_size:0]   read_to_write_pointer_i,
  output logic                 write_accept_o,
  output logic [addr_size-1:0] write_address_o,
  output logic [addr_size:0]   write_pointer_o,
  output logic                 write_full_o,
  output logic                 write_almost_full_o,
  output logic [addr_size:0]   write_level_o,
  output logic                 overflow_o
);
  localparam logic [addr_size:0] af_level = (addr_size+1)'((1 << addr_size) - almost_full_margin);
  logic [addr_size:0] wbin_q, wbin_d, wgray_q, wgray_d, level_q, level_d, rbin;
  logic full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= addr_size; i++) rbin[i] = ^(read_to_write_pointer_i >> i);
  end
  assign write_accept_o = write_enable_i & ~full_q;
  assign wbin_d  = wbin_q + (addr_size+1)'(write_accept_o);
  assign wgray_d = (wbin_d >> 1) ^ wbin_d;
  // full when the next write pointer is one lap ahead of the read pointer
  assign full_d  = wgray_d == {~read_to_write_pointer_i[addr_size:addr_size-1],
                               read_to_write_pointer_i[addr_size-2:0]};
  assign level_d = wbin_d - rbin;
  assign afull_d = level_d >= af_level;
  assign ovf_d   = (write_enable_i & full_q) | (ovf_q & ~overflow_clear_i);
  always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end
  assign write_address_o     = wbin_q[addr_size-1:0];
  assign write_pointer_o     = wgray_q;
  assign write_full_o        = full_q;
  assign write_almost_full_o = afull_q;
  assign write_level_o       = level_q;
  assign overflow_o          = ovf_q;
endmodule

// File: tb/tb_write_pointer_full_block.sv
// tb_write_pointer_full_block: vector table plus scoreboarded sequences for reset, fill, overflow, release and wrap
module tb_write_pointer_full_block;
  logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, clr = 1'b0;
  logic [4:0] rq = '0;
  logic acc_o, full_o, af_o, ovf_o;
  logic [3:0] addr_o;
  logic [4:0] ptr_o, lvl_o;
  int checks = 0, errors = 0;

  typedef struct {
    logic we, clr;
    logic [4:0] rb;
    logic acc;
    logic [4:0] wbin, lvl;
    logic full, af, ovf;
  } vec_t;

  vec_t tbl[21];
  vec_t exp_q[$];

  write_pointer_full_block #(.addr_size(4), .almost_full_margin(2)) dut (
    .write_clock_i(clk), .write_reset_n_i(rst_n), .write_enable_i(we),
    .overflow_clear_i(clr), .read_to_write_pointer_i(rq), .write_accept_o(acc_o),
    .write_address_o(addr_o), .write_pointer_o(ptr_o), .write_full_o(full_o),
    .write_almost_full_o(af_o), .write_level_o(lvl_o), .overflow_o(ovf_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic c, input logic [4:0] rb, input logic a,
                              input logic [4:0] wb, input logic [4:0] l, input logic f,
                              input logic af, input logic o);
    vec_t v;
    v.we = w; v.clr = c; v.rb = rb; v.acc = a; v.wbin = wb; v.lvl = l;
    v.full = f; v.af = af; v.ovf = o;
    return v;
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    we = v.we; clr = v.clr; rq = gray(v.rb);
    #1 check("accept", acc_o, v.acc);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("addr", addr_o, e.wbin[3:0]);
    check("ptr", ptr_o, gray(e.wbin));
    check("level", lvl_o, e.lvl);
    check("full", full_o, e.full);
    check("almost_full", af_o, e.af);
    check("overflow", ovf_o, e.ovf);
  endtask

  initial begin
    logic [4:0] wb, prev;
    for (int i = 0; i < 16; i++)
      tbl[i] = mk(1, 0, 5'd0, 1, 5'(i + 1), 5'(i + 1), i == 15, i >= 13, 0);
    tbl[16] = mk(1, 0, 5'd0, 0, 5'd16, 5'd16, 1, 1, 1);
    tbl[17] = mk(0, 1, 5'd0, 0, 5'd16, 5'd16, 1, 1, 0);
    tbl[18] = mk(1, 1, 5'd0, 0, 5'd16, 5'd16, 1, 1, 1);
    tbl[19] = mk(0, 0, 5'd4, 0, 5'd16, 5'd12, 0, 0, 1);
    tbl[20] = mk(0, 1, 5'd4, 0, 5'd16, 5'd12, 0, 0, 0);

    #1;
    check("reset_full", full_o, 0);
    check("reset_ptr", ptr_o, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step(mk(1, 0, 5'd0, 1, 5'(i + 1), 5'(i + 1), 0, 0, 0));
    // asynchronous reset in the middle of the low phase, mid-burst at wbin = 7
    @(negedge clk);
    we = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", addr_o, 0);
    check("arst_ptr", ptr_o, 0);
    check("arst_level", lvl_o, 0);
    check("arst_full", full_o, 0);
    check("arst_af", af_o, 0);
    check("arst_ovf", ovf_o, 0);
    check("arst_accept", acc_o, 1);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    step(mk(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0));
    step(mk(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    wb = 5'd16;
    for (int k = 0; k < 40; k++) begin
      prev = ptr_o;
      step(mk(1, 0, wb - 5'd1, 1, wb + 5'd1, 5'd2, 0, 0, 0));
      check("gray_one_bit", $countones(prev ^ ptr_o), 1);
      wb = wb + 5'd1;
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_pointer_full_block.md
# write_pointer_full_block

Write-domain control for the async FIFO: the write-side counterpart of the read-to-write pointer synchronizer. It owns the write pointer (binary address plus Gray-coded pointer exported to the read domain). It compares that pointer against the synchronized read pointer to generate full, almost-full, fill level and overflow status. It sits between the FIFO's push interface and the dual-port memory / write-to-read synchronizer.

## Interface
- addr_size, 4, memory address width; FIFO depth = 2^addr_size
- almost_full_margin, 2, almost-full asserts when free entries ≤ this value

- write_clock_i  in  1  write-domain clock
- write_reset_n_i  in  1  reset, asynchronous, active-low
- write_enable_i  in  1  push request
- overflow_clear_i  in  1  clears sticky overflow flag
- read_to_write_pointer_i  in  addr_size+1  Gray read pointer, already synchronized into write domain
- write_accept_o  out  1  push accepted this cycle; memory write enable
- write_address_o  out  addr_size  binary memory write address
- write_pointer_o  out  addr_size+1  registered Gray write pointer, to write-to-read synchronizer
- write_full_o  out  1  FIFO full (registered)
- write_almost_full_o  out  1  free entries ≤ almost_full_margin (registered)
- write_level_o  out  addr_size+1  occupied entries as seen by write side, 0..2^addr_size (registered)
- overflow_o  out  1  sticky: push requested while full

## Operation
- Internal binary counter wbin[addr_size:0]; write_address_o = wbin[addr_size-1:0]; write_pointer_o = registered Gray of wbin.
- write_accept_o = write_enable_i & ~write_full_o (combinational, no other term).
- wbin_next = wbin + write_accept_o, modulo 2^(addr_size+1); wgray_next = (wbin_next >> 1) ^ wbin_next.
- Read pointer converted Gray→binary combinationally: rbin[addr_size] = g[addr_size]; rbin[i] = rbin[i+1] ^ g[i].
- full_next = (wgray_next == {~rq[addr_size:addr_size-1], rq[addr_size-2:0]}), where rq = read_to_write_pointer_i.
- level_next = wbin_next − rbin, modulo 2^(addr_size+1).
- almost_full_next = (level_next ≥ 2^addr_size − almost_full_margin).
- Overflow: set when write_enable_i & write_full_o; else cleared when overflow_clear_i; set wins over a simultaneous clear.
- Reset (async, any time, including mid-burst): wbin = 0, write_pointer_o = 0, write_address_o = 0, write_full_o = 0, write_almost_full_o = 0, write_level_o = 0, overflow_o = 0. write_accept_o then follows write_enable_i.
- No state machine beyond counter and flags. All registers are clocked on the posedge of write_clock_i.

## Timing
- Accepted push: memory writes at write_address_o on the same edge that wbin, write_pointer_o, full, almost-full and level update. Zero-cycle accept latency.
- Full asserts on the edge that accepts the entry filling the last slot. The next push is rejected in the following cycle.
- Full/level/almost-full deassert or decrease one write-clock edge after read_to_write_pointer_i changes. They are pessimistic by the upstream synchronizer delay; full never deasserts early.
- A simultaneous accepted push and read-pointer change is evaluated together on the same edge using wbin_next and the current rq.
- Wrap-around: wbin wraps from 2^(addr_size+1)−1 to 0. Gray changes exactly one bit per accepted push, including at wrap.
- write_pointer_o changes only on accepted pushes, so it is safe to double-sync.

## Test plan
- Reset: assert write_reset_n_i mid-burst with wbin = 7 → all outputs 0 immediately (asynchronous), and they remain 0 until the first accepted push after release.
- Fill (addr_size = 4, rq = 5'b00000): 16 consecutive pushes → write_address_o steps 0..15. After the 16th edge: write_full_o = 1, write_level_o = 16, write_pointer_o = 5'b11000.
- Almost-full (margin 2): push 13 entries with rq = 0 → write_almost_full_o = 0. The 14th push → write_almost_full_o = 1, write_level_o = 14.
- Overflow: while full, drive write_enable_i = 1 for 1 cycle → write_accept_o = 0, wbin unchanged, overflow_o = 1. Pulse overflow_clear_i → overflow_o = 0. Clear and overflow in the same cycle → overflow_o stays 1.
- Release from full: with full at wbin = 16, set rq = Gray(4) = 5'b00110 → one edge later write_full_o = 0, write_level_o = 12, write_almost_full_o = 0.
- Wrap: with rq tracking wbin minus 1, push 40 entries → write_pointer_o progresses through Gray sequence 0..31 then back to 0. Exactly one bit changes per push, and write_full_o is never 1.
